gpio_blink_arb: RTL

GPIO_BLINK_ARB -- requirements
Module: gpio_blink_arb

---
 rtl/gpio_blink_arb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gpio_blink_arb.sv
// Round-robin arbiter that lends a shared 36-bit GPIO bank to one of four
// requesters and blinks that requester's pin pattern a requested number of times.
module gpio_blink_arb #(
  parameter logic [31:0] HALF_PERIOD = 32'd50_000_000
) (
  input  logic         clk50,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [143:0] mask,
  input  logic [31:0]  blinks,
  output logic [3:0]   gnt,
  output logic [3:0]   done,
  output logic         busy,
  output logic [35:0]  gpio,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam logic [31:0] HP_M1 = HALF_PERIOD - 32'd1;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [31:0] phase_q, phase_d;
  logic [7:0]  left_q, left_d;
  logic [35:0] mask_q, mask_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic [35:0] gpio_q, gpio_d;

  logic        found;
  logic [1:0]  sel;
  logic [1:0]  cand;
  logic [35:0] sel_mask;
  logic [7:0]  sel_blinks;

  // Search starts just after the last grant, so the last winner ranks lowest.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    sel_mask   = mask[36*sel +: 36];
    sel_blinks = blinks[8*sel +: 8];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    phase_d = phase_q;
    left_d  = left_q;
    mask_d  = mask_q;
    gnt_d   = gnt_q;
    done_d  = 4'b0000;
    busy_d  = busy_q;
    gpio_d  = gpio_q;
    case (state_q)
      IDLE: begin
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        gpio_d  = '0;
        phase_d = '0;
        if (found) begin
          ptr_d  = sel;
          mask_d = sel_mask;
          left_d = sel_blinks;
          if (sel_blinks == 8'd0) begin
            done_d = 4'b0001 << sel;
          end else begin
            state_d = ON;
            gnt_d   = 4'b0001 << sel;
            busy_d  = 1'b1;
            gpio_d  = sel_mask;
          end
        end
      end
      ON: begin
        if (phase_q == HP_M1) begin
          phase_d = '0;
          state_d = OFF;
          gpio_d  = '0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      OFF: begin
        if (phase_q == HP_M1) begin
          phase_d = '0;
          left_d  = left_q - 8'd1;
          if (left_q == 8'd1) begin
            state_d = IDLE;
            done_d  = gnt_q;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            gpio_d  = '0;
          end else begin
            state_d = ON;
            gpio_d  = mask_q;
          end
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      phase_q <= '0;
      left_q  <= '0;
      mask_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      gpio_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      phase_q <= phase_d;
      left_q  <= left_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      gpio_q  <= gpio_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign gpio      = gpio_q;
  assign dbg_state = state_q;

endmodule
